// File: rtl/vga_timing_gen.sv
// VGA raster generator fed by the myVGA register bank.
// Produces a pixel-clock enable, sync timing, pixel coordinates and 12-bit RGB from a
// small pattern engine, plus a frame counter and vblank status for software.
`timescale 1ns / 1ps

module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIX_DIV  = 4
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] ctrl_reg,
  input  logic [31:0] fg_color,
  input  logic [31:0] bg_color,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        video_active,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        vblank,
  output logic        vblank_pulse,
  output logic [15:0] frame_cnt
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(PIX_DIV - 1);

  localparam logic [9:0] HLast      = 10'(HTotal - 1);
  localparam logic [9:0] VLast      = 10'(VTotal - 1);
  localparam logic [9:0] HActive    = 10'(H_ACTIVE);
  localparam logic [9:0] VActive    = 10'(V_ACTIVE);
  localparam logic [9:0] HActLast   = 10'(H_ACTIVE - 1);
  localparam logic [9:0] VActLast   = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);
  // Eight equal colour bars across the visible line.
  localparam logic [9:0] BarW       = 10'(H_ACTIVE / 8);

  logic            enable;
  logic [DivW-1:0] div_q;
  logic            div_last;
  logic            pix_ce;
  logic [9:0]      h_q;
  logic [9:0]      v_q;
  logic            h_last;
  logic            v_last;
  logic            frame_wrap;

  logic [1:0]      mode_q;
  logic            pol_q;
  logic [11:0]     fg_q;
  logic [11:0]     bg_q;

  logic            in_active;
  logic            in_hsync;
  logic            in_vsync;
  logic [2:0]      bar_idx;
  logic [11:0]     pat;
  logic [11:0]     rgb_d;

  logic            unused_bits;

  assign enable     = ctrl_reg[0];
  assign div_last   = (div_q == DivLast);
  assign pix_ce     = enable && div_last;
  assign h_last     = (h_q == HLast);
  assign v_last     = (v_q == VLast);
  // Not gated by enable: a disable landing on the wrap cycle still counts the frame.
  assign frame_wrap = div_last && h_last && v_last;

  assign unused_bits = ^{ctrl_reg[31:4], fg_color[31:12], bg_color[31:12]};

  // Pixel divider: one pix_ce every PIX_DIV cycles, held at 0 while disabled.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      div_q <= '0;
    end else if (!enable || div_last) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Raster counters advance on pix_ce and restart from (0,0) whenever disabled.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      h_q <= '0;
      v_q <= '0;
    end else if (!enable) begin
      h_q <= '0;
      v_q <= '0;
    end else if (pix_ce) begin
      if (h_last) begin
        h_q <= '0;
        v_q <= v_last ? '0 : v_q + 10'd1;
      end else begin
        h_q <= h_q + 10'd1;
      end
    end
  end

  // Shadow copies so register writes only take effect at a frame boundary.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      mode_q <= '0;
      pol_q  <= 1'b0;
      fg_q   <= '0;
      bg_q   <= '0;
    end else if (!enable || frame_wrap) begin
      mode_q <= ctrl_reg[2:1];
      pol_q  <= ctrl_reg[3];
      fg_q   <= fg_color[11:0];
      bg_q   <= bg_color[11:0];
    end
  end

  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      frame_cnt <= '0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Region decode and pattern engine for the current counter position.
  always_comb begin
    in_active = (h_q < HActive) && (v_q < VActive);
    in_hsync  = (h_q >= HSyncStart) && (h_q < HSyncEnd);
    in_vsync  = (v_q >= VSyncStart) && (v_q < VSyncEnd);
    bar_idx   = 3'(h_q / BarW);
    pat       = fg_q;
    case (mode_q)
      2'b00: pat = fg_q;
      2'b01: pat = {{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}};
      2'b10: pat = (h_q[5] ^ v_q[5]) ? fg_q : bg_q;
      2'b11: pat = ((h_q == 10'd0) || (h_q == HActLast) || (v_q == 10'd0) ||
                    (v_q == VActLast)) ? fg_q : bg_q;
      default: pat = fg_q;
    endcase
    rgb_d = in_active ? pat : 12'h000;
  end

  // Output stage: one pixel behind the counters, idle while disabled.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
      video_active <= 1'b0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      vblank       <= 1'b0;
      vblank_pulse <= 1'b0;
    end else if (!enable) begin
      hsync        <= ~ctrl_reg[3];
      vsync        <= ~ctrl_reg[3];
      red          <= '0;
      green        <= '0;
      blue         <= '0;
      video_active <= 1'b0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      vblank       <= 1'b0;
      vblank_pulse <= 1'b0;
    end else begin
      vblank_pulse <= 1'b0;
      if (pix_ce) begin
        hsync        <= in_hsync ? pol_q : ~pol_q;
        vsync        <= in_vsync ? pol_q : ~pol_q;
        red          <= rgb_d[11:8];
        green        <= rgb_d[7:4];
        blue         <= rgb_d[3:0];
        video_active <= in_active;
        pixel_x      <= h_q;
        pixel_y      <= v_q;
        vblank       <= (v_q >= VActive);
        vblank_pulse <= (v_q == VActive) && (h_q == 10'd0);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with a shortened raster so full frames stay cheap.
`timescale 1ns / 1ps

module tb_vga_timing_gen;

  localparam int unsigned HA  = 640;
  localparam int unsigned HFP = 8;
  localparam int unsigned HS  = 16;
  localparam int unsigned HBP = 8;
  localparam int unsigned VA  = 34;
  localparam int unsigned VFP = 2;
  localparam int unsigned VS  = 2;
  localparam int unsigned VBP = 2;
  localparam int unsigned PD  = 2;
  localparam int unsigned HT  = HA + HFP + HS + HBP;  // 672
  localparam int unsigned VT  = VA + VFP + VS + VBP;  // 40

  logic        ACLK;
  logic        ARESETN;
  logic [31:0] ctrl_reg;
  logic [31:0] fg_color;
  logic [31:0] bg_color;
  logic        hsync;
  logic        vsync;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        video_active;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        vblank;
  logic        vblank_pulse;
  logic [15:0] frame_cnt;
  logic [11:0] rgb;

  int unsigned edges;
  int          checks;
  int          errors;

  assign rgb = {red, green, blue};

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .PIX_DIV(PD)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .ctrl_reg    (ctrl_reg),
    .fg_color    (fg_color),
    .bg_color    (bg_color),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .video_active(video_active),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .vblank      (vblank),
    .vblank_pulse(vblank_pulse),
    .frame_cnt   (frame_cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    edges++;
    #1;
  endtask

  // Advance until the edge that registers pixel (x,y) of frame f since enable.
  task automatic goto(input int unsigned x, input int unsigned y, input int unsigned f);
    int unsigned target;
    target = PD * (1 + f * HT * VT + y * HT + x);
    while (edges < target) step();
  endtask

  // Present settings while disabled so the shadows load them, then enable.
  task automatic start(input logic [31:0] ctrl, input logic [31:0] fg, input logic [31:0] bg);
    ctrl_reg = ctrl & ~32'h1;
    fg_color = fg;
    bg_color = bg;
    step();
    step();
    ctrl_reg = ctrl;
    edges    = 0;
  endtask

  task automatic test_reset();
    ARESETN  = 1'b0;
    ctrl_reg = 32'h0;
    fg_color = 32'h0;
    bg_color = 32'h0;
    repeat (3) @(posedge ACLK);
    #1;
    checks++;
    if ({hsync, vsync, video_active, vblank, vblank_pulse} !== 5'b11000) begin
      errors++;
      $display("FAIL rst_flags got %b want %b", {hsync, vsync, video_active, vblank,
               vblank_pulse}, 5'b11000);
    end
    checks++;
    if ({rgb, pixel_x, pixel_y, frame_cnt} !== 48'h0) begin
      errors++;
      $display("FAIL rst_values got %h want 0", {rgb, pixel_x, pixel_y, frame_cnt});
    end
    ARESETN = 1'b1;
    step();
    step();
    checks++;
    if ({hsync, vsync, video_active, rgb} !== 15'b110_0000_0000_0000) begin
      errors++;
      $display("FAIL idle_after_rst got %b want %b", {hsync, vsync, video_active, rgb},
               15'b110_0000_0000_0000);
    end
  endtask

  task automatic test_first_pixel();
    start(32'h1, 32'hF00, 32'h0);
    step();
    checks++;
    if ({video_active, rgb} !== 13'h0) begin
      errors++;
      $display("FAIL latency_early got %h want 0", {video_active, rgb});
    end
    goto(0, 0, 0);
    checks++;
    if ({video_active, rgb, pixel_x, pixel_y} !== {1'b1, 12'hF00, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL px00 got %h want %h", {video_active, rgb, pixel_x, pixel_y},
               {1'b1, 12'hF00, 10'd0, 10'd0});
    end
    step();
    checks++;
    if ({rgb, pixel_x} !== {12'hF00, 10'd0}) begin
      errors++;
      $display("FAIL px00_hold got %h want %h", {rgb, pixel_x}, {12'hF00, 10'd0});
    end
    goto(1, 0, 0);
    checks++;
    if (pixel_x !== 10'd1) begin
      errors++;
      $display("FAIL px1 got %0d want 1", pixel_x);
    end
    goto(639, 0, 0);
    checks++;
    if ({video_active, rgb} !== {1'b1, 12'hF00}) begin
      errors++;
      $display("FAIL px639 got %h want %h", {video_active, rgb}, {1'b1, 12'hF00});
    end
    goto(640, 0, 0);
    checks++;
    if ({video_active, rgb} !== 13'h0) begin
      errors++;
      $display("FAIL px640 got %h want 0", {video_active, rgb});
    end
    goto(647, 0, 0);
    checks++;
    if (hsync !== 1'b1) begin
      errors++;
      $display("FAIL hs_647 got %b want 1", hsync);
    end
    goto(648, 0, 0);
    checks++;
    if (hsync !== 1'b0) begin
      errors++;
      $display("FAIL hs_648 got %b want 0", hsync);
    end
    goto(663, 0, 0);
    checks++;
    if (hsync !== 1'b0) begin
      errors++;
      $display("FAIL hs_663 got %b want 0", hsync);
    end
    goto(664, 0, 0);
    checks++;
    if (hsync !== 1'b1) begin
      errors++;
      $display("FAIL hs_664 got %b want 1", hsync);
    end
    goto(648, 1, 0);
    checks++;
    if ({hsync, pixel_y, vsync} !== {1'b0, 10'd1, 1'b1}) begin
      errors++;
      $display("FAIL hs_line1 got %h want %h", {hsync, pixel_y, vsync}, {1'b0, 10'd1, 1'b1});
    end
  endtask

  task automatic test_bars();
    start(32'h3, 32'h0, 32'h0);
    goto(0, 0, 0);
    checks++;
    if (rgb !== 12'h000) begin
      errors++;
      $display("FAIL bar_0 got %h want 000", rgb);
    end
    goto(85, 0, 0);
    checks++;
    if (rgb !== 12'h00F) begin
      errors++;
      $display("FAIL bar_85 got %h want 00F", rgb);
    end
    goto(480, 0, 0);
    checks++;
    if (rgb !== 12'hFF0) begin
      errors++;
      $display("FAIL bar_480 got %h want FF0", rgb);
    end
    goto(560, 0, 0);
    checks++;
    if (rgb !== 12'hFFF) begin
      errors++;
      $display("FAIL bar_560 got %h want FFF", rgb);
    end
    goto(640, 0, 0);
    checks++;
    if ({video_active, rgb} !== 13'h0) begin
      errors++;
      $display("FAIL bar_640 got %h want 0", {video_active, rgb});
    end
  endtask

  task automatic test_border();
    start(32'h7, 32'hF00, 32'h00F);
    goto(5, 0, 0);
    checks++;
    if (rgb !== 12'hF00) begin
      errors++;
      $display("FAIL brd_5_0 got %h want F00", rgb);
    end
    goto(0, 1, 0);
    checks++;
    if (rgb !== 12'hF00) begin
      errors++;
      $display("FAIL brd_0_1 got %h want F00", rgb);
    end
    goto(5, 1, 0);
    checks++;
    if (rgb !== 12'h00F) begin
      errors++;
      $display("FAIL brd_5_1 got %h want 00F", rgb);
    end
    goto(639, 1, 0);
    checks++;
    if (rgb !== 12'hF00) begin
      errors++;
      $display("FAIL brd_639_1 got %h want F00", rgb);
    end
  endtask

  task automatic test_checker_frame();
    start(32'h5, 32'h000, 32'hFFF);
    goto(31, 0, 0);
    checks++;
    if (rgb !== 12'hFFF) begin
      errors++;
      $display("FAIL chk_31_0 got %h want FFF", rgb);
    end
    goto(32, 0, 0);
    checks++;
    if (rgb !== 12'h000) begin
      errors++;
      $display("FAIL chk_32_0 got %h want 000", rgb);
    end
    goto(0, 10, 0);
    bg_color = 32'h0F0;
    goto(0, 12, 0);
    checks++;
    if (rgb !== 12'hFFF) begin
      errors++;
      $display("FAIL shadow_hold got %h want FFF", rgb);
    end
    goto(32, 32, 0);
    checks++;
    if (rgb !== 12'hFFF) begin
      errors++;
      $display("FAIL chk_32_32 got %h want FFF", rgb);
    end
    goto(HT - 1, VA - 1, 0);
    checks++;
    if ({vblank, vblank_pulse} !== 2'b00) begin
      errors++;
      $display("FAIL vbl_before got %b want 00", {vblank, vblank_pulse});
    end
    goto(0, VA, 0);
    checks++;
    if ({vblank, vblank_pulse, video_active, rgb, pixel_y} !==
        {1'b1, 1'b1, 1'b0, 12'h0, 10'(VA)}) begin
      errors++;
      $display("FAIL vbl_entry got %h want %h", {vblank, vblank_pulse, video_active, rgb,
               pixel_y}, {1'b1, 1'b1, 1'b0, 12'h0, 10'(VA)});
    end
    step();
    checks++;
    if ({vblank, vblank_pulse} !== 2'b10) begin
      errors++;
      $display("FAIL vbl_pulse_width got %b want 10", {vblank, vblank_pulse});
    end
    goto(0, VA + VFP - 1, 0);
    checks++;
    if (vsync !== 1'b1) begin
      errors++;
      $display("FAIL vs_before got %b want 1", vsync);
    end
    goto(0, VA + VFP, 0);
    checks++;
    if (vsync !== 1'b0) begin
      errors++;
      $display("FAIL vs_start got %b want 0", vsync);
    end
    goto(HT - 1, VA + VFP + VS - 1, 0);
    checks++;
    if (vsync !== 1'b0) begin
      errors++;
      $display("FAIL vs_last got %b want 0", vsync);
    end
    goto(0, VA + VFP + VS, 0);
    checks++;
    if (vsync !== 1'b1) begin
      errors++;
      $display("FAIL vs_end got %b want 1", vsync);
    end
    goto(HT - 2, VT - 1, 0);
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL fcnt_pre got %0d want 0", frame_cnt);
    end
    goto(HT - 1, VT - 1, 0);
    checks++;
    if ({frame_cnt, vblank} !== {16'd1, 1'b1}) begin
      errors++;
      $display("FAIL fcnt_wrap got %h want %h", {frame_cnt, vblank}, {16'd1, 1'b1});
    end
    goto(0, 0, 1);
    checks++;
    if ({rgb, vblank, pixel_x, pixel_y} !== {12'h0F0, 1'b0, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL next_frame_00 got %h want %h", {rgb, vblank, pixel_x, pixel_y},
               {12'h0F0, 1'b0, 10'd0, 10'd0});
    end
    goto(32, 0, 1);
    checks++;
    if (rgb !== 12'h000) begin
      errors++;
      $display("FAIL next_frame_32 got %h want 000", rgb);
    end
  endtask

  task automatic test_polarity();
    ctrl_reg = 32'h8;
    step();
    checks++;
    if ({hsync, vsync} !== 2'b00) begin
      errors++;
      $display("FAIL pol_idle got %b want 00", {hsync, vsync});
    end
    start(32'h9, 32'hF00, 32'h0);
    goto(647, 0, 0);
    checks++;
    if ({hsync, vsync} !== 2'b00) begin
      errors++;
      $display("FAIL pol_647 got %b want 00", {hsync, vsync});
    end
    goto(648, 0, 0);
    checks++;
    if ({hsync, vsync} !== 2'b10) begin
      errors++;
      $display("FAIL pol_648 got %b want 10", {hsync, vsync});
    end
  endtask

  task automatic test_disable_midframe();
    start(32'h1, 32'hF00, 32'h0);
    goto(10, 5, 0);
    checks++;
    if ({rgb, pixel_x, pixel_y} !== {12'hF00, 10'd10, 10'd5}) begin
      errors++;
      $display("FAIL pre_disable got %h want %h", {rgb, pixel_x, pixel_y},
               {12'hF00, 10'd10, 10'd5});
    end
    ctrl_reg = 32'h0;
    step();
    checks++;
    if ({hsync, vsync, video_active, vblank, vblank_pulse, rgb, pixel_x, pixel_y} !==
        {5'b11000, 12'h0, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL disable_idle got %h want %h", {hsync, vsync, video_active, vblank,
               vblank_pulse, rgb, pixel_x, pixel_y}, {5'b11000, 12'h0, 10'd0, 10'd0});
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL disable_fcnt got %0d want 1", frame_cnt);
    end
    ctrl_reg = 32'h1;
    edges    = 0;
    repeat (PD - 1) step();
    checks++;
    if ({video_active, rgb} !== 13'h0) begin
      errors++;
      $display("FAIL reen_early got %h want 0", {video_active, rgb});
    end
    goto(0, 0, 0);
    checks++;
    if ({video_active, rgb, pixel_x, pixel_y} !== {1'b1, 12'hF00, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL reen_px00 got %h want %h", {video_active, rgb, pixel_x, pixel_y},
               {1'b1, 12'hF00, 10'd0, 10'd0});
    end
  endtask

  task automatic test_async_reset();
    start(32'h1, 32'hF00, 32'h0);
    goto(5, 1, 0);
    #2;
    ARESETN = 1'b0;
    #1;
    checks++;
    if ({hsync, vsync, video_active, vblank, vblank_pulse, rgb, pixel_x, pixel_y,
         frame_cnt} !== {5'b11000, 12'h0, 10'd0, 10'd0, 16'd0}) begin
      errors++;
      $display("FAIL async_rst got %h want %h", {hsync, vsync, video_active, vblank,
               vblank_pulse, rgb, pixel_x, pixel_y, frame_cnt},
               {5'b11000, 12'h0, 10'd0, 10'd0, 16'd0});
    end
    #2;
    ARESETN = 1'b1;
  endtask

  initial begin
    edges  = 0;
    checks = 0;
    errors = 0;
    test_reset();
    test_first_pixel();
    test_bars();
    test_border();
    test_checker_frame();
    test_polarity();
    test_disable_midframe();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
